booth_prod_accum: RTL and testbench
===================================

BOOTH_PROD_ACCUM -- requirements
Module: booth_prod_accum

Interface
REQ-001 The block SHALL have parameter ACC_W, default 24, giving the accumulator width in bits (legal range 16..32).
REQ-002 The block SHALL have parameter N_PROD, default 4, giving the number of products summed per result (legal range 1..255).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port p_in, input, 16 bits: two's-complement product from the upstream Booth multiplier.
REQ-006 Port p_rdy, input, 1 bit: the upstream done level; it stays high once a product is final.
REQ-007 Port clr, input, 1 bit: synchronous clear of the accumulation in progress.
REQ-008 Port acc_out, output, ACC_W bits: signed accumulated result.
REQ-009 Port acc_valid, output, 1 bit: acc_out holds a completed result.
REQ-010 Port acc_ready, input, 1 bit: downstream accept.
REQ-011 Port ovf, output, 1 bit: sticky flag for arithmetic overflow or saturation.
REQ-012 Port drop_err, output, 1 bit: sticky flag for a lost product.

Function
REQ-013 A product event SHALL be the cycle in which p_rdy is 1 and its registered previous value is 0, i.e. a rising-edge detect.
REQ-014 On a product event, p_in SHALL be sampled in that same cycle and sign-extended to ACC_W bits.
REQ-015 FSM states SHALL be IDLE, ACCUM and HOLD; the reset state is IDLE.
REQ-016 IDLE -> ACCUM on the first product event: acc is loaded with the product and cnt is set to 1.
REQ-017 In ACCUM, each product event SHALL do acc <= acc + product and cnt <= cnt + 1.
REQ-018 When cnt reaches N_PROD, the FSM SHALL enter HOLD and assert acc_valid starting the next cycle; latency from the last event to acc_valid is 1 cycle.
REQ-019 With N_PROD = 1, the first event SHALL go directly IDLE -> HOLD.
REQ-020 In HOLD, acc_out and acc_valid SHALL stay stable until acc_valid && acc_ready is seen at a clock edge.
REQ-021 On that handshake the FSM SHALL return to IDLE and clear acc and cnt.
REQ-022 Pending register: one product event arriving in HOLD SHALL be stored in a 1-entry pending register.
REQ-023 On the handshake, a stored pending product SHALL seed the next accumulation (HOLD -> ACCUM with cnt = 1) instead of going to IDLE.
REQ-024 A second event while the pending register is full SHALL be discarded and SHALL set drop_err.
REQ-025 A product event coincident with the handshake cycle SHALL be treated as arriving after the handshake; it is not dropped.
REQ-026 clr = 1 SHALL force IDLE and zero acc, cnt, acc_valid and the pending register, with priority over all other events in that cycle.
REQ-027 clr SHALL NOT clear ovf or drop_err; only reset clears them.
REQ-028 Signed overflow of an add (operands of equal sign, result of the opposite sign) SHALL set ovf.
REQ-029 acc_out SHALL equal acc while in HOLD and SHALL be 0 otherwise.

Reset
REQ-030 While reset_n = 0, the following SHALL hold asynchronously: state = IDLE, acc = 0, cnt = 0, pending empty, edge-detect register = 0, acc_out = 0, acc_valid = 0, ovf = 0, drop_err = 0.
REQ-031 A reset asserted mid-accumulation or in HOLD SHALL discard all partial and pending data.
REQ-032 After reset_n deasserts, a p_rdy that is already high SHALL NOT count as an event until it goes low and then high again.

Configuration
REQ-033 Macro BOOTH_ACC_SAT_EN SHALL select the overflow behaviour.
REQ-034 With BOOTH_ACC_SAT_EN defined, an overflowing add SHALL clamp to +(2^(ACC_W-1) - 1) or -2^(ACC_W-1) and set ovf.
REQ-035 With BOOTH_ACC_SAT_EN undefined, the add SHALL wrap modulo 2^ACC_W and set ovf.

Structure
REQ-036 The shared package booth_pkg SHALL hold the FSM state enum (IDLE, ACCUM, HOLD), the constant PROD_W = 16, and the saturation min/max helper constants.
REQ-037 The rising-edge detect SHALL be one sub-module, booth_rdy_edge (inputs clk, reset_n, level; output pulse); all other logic stays inline.

Verification
REQ-038 Scenario 1 (N_PROD = 4): products 100, 200, -50, 10, each given as a p_rdy low-high pulse -> acc_out = 260, acc_valid = 1 one cycle after the fourth event.
REQ-039 Scenario 2 (backpressure): hold acc_ready = 0 for 5 cycles in HOLD and send one product of 7 -> acc_out is stable throughout; after acceptance the next result starts with acc = 7, cnt = 1; send a third event while pending is full -> drop_err = 1.
REQ-040 Scenario 3 (ACC_W = 16, N_PROD = 3, products 16384 x3): with BOOTH_ACC_SAT_EN defined -> acc_out = 32767, ovf = 1; without it -> acc_out = -16384, ovf = 1.
REQ-041 Scenario 4: assert clr after 2 of 4 products, then send 5, 5, 5, 5 -> acc_out = 20, and ovf/drop_err are unchanged by clr.
REQ-042 Scenario 5: pulse reset_n low in ACCUM while p_rdy stays high -> all outputs are 0 and no event fires until p_rdy toggles low then high.
REQ-043 Scenario 6: product event in the same cycle as the acc_valid && acc_ready handshake -> the product starts the new accumulation with cnt = 1 and drop_err stays 0.

Source files
------------

// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared types and constants for the Booth product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int unsigned PROD_W = 16;
  localparam int unsigned CNT_W  = 8;

  // Saturation bit patterns for a w-bit two's-complement accumulator (low w bits valid)
  function automatic logic [31:0] sat_max_pat(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_min_pat(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_rdy_edge.sv
`default_nettype none
// ============================================================================
// Module      : booth_rdy_edge
// Description : Rising-edge detector on the upstream done level; a level that
//               is already high when reset releases is not reported.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_rdy_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic pulse
);

  logic prev_q, prev_d;
  logic armed_q, armed_d;

  always_comb begin
    prev_d  = level;
    armed_d = armed_q | ~level;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign pulse = level & ~prev_q & armed_q;

endmodule
`default_nettype wire

// File: rtl/booth_prod_accum.sv
`default_nettype none
// ============================================================================
// Module      : booth_prod_accum
// Description : Sums N_PROD signed Booth products into one result held until
//               accepted, with a 1-entry pending slot for early products.
//               Define BOOTH_ACC_SAT_EN to saturate instead of wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_prod_accum
  import booth_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter int N_PROD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PROD_W-1:0] p_in,
  input  logic              p_rdy,
  input  logic              clr,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              ovf,
  output logic              drop_err
);

  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_PROD);

`ifdef BOOTH_ACC_SAT_EN
  localparam logic [31:0]      SAT_MAX_W = sat_max_pat(ACC_W);
  localparam logic [31:0]      SAT_MIN_W = sat_min_pat(ACC_W);
  localparam logic [ACC_W-1:0] SAT_MAX   = SAT_MAX_W[ACC_W-1:0];
  localparam logic [ACC_W-1:0] SAT_MIN   = SAT_MIN_W[ACC_W-1:0];
`endif

  state_e             state_q, state_d, state_b;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_b;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_b;
  logic               pend_v_q, pend_v_d, pend_v_b;
  logic [PROD_W-1:0]  pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               drop_q, drop_d;
  logic               acc_valid_q, acc_valid_d;
  logic [ACC_W-1:0]   acc_out_q, acc_out_d;

  logic               ev;
  logic               hs;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   pend_ext;
  logic [ACC_W-1:0]   sum;
  logic [ACC_W-1:0]   add_res;
  logic               add_ovf;
  logic [CNT_W-1:0]   cnt_inc;

  booth_rdy_edge u_rdy_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (p_rdy),
    .pulse   (ev)
  );

  assign hs       = acc_valid_q & acc_ready;
  assign prod_ext = ACC_W'($signed(p_in));
  assign pend_ext = ACC_W'($signed(pend_q));

  // Handshake is resolved first so a coincident product lands in the next result
  always_comb begin
    state_b  = state_q;
    acc_b    = acc_q;
    cnt_b    = cnt_q;
    pend_v_b = pend_v_q;
    if (hs) begin
      if (pend_v_q) begin
        state_b  = (N_LAST == CNT_W'(1)) ? HOLD : ACCUM;
        acc_b    = pend_ext;
        cnt_b    = CNT_W'(1);
        pend_v_b = 1'b0;
      end else begin
        state_b = IDLE;
        acc_b   = '0;
        cnt_b   = '0;
      end
    end
  end

  assign sum     = acc_b + prod_ext;
  assign add_ovf = (acc_b[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_b[ACC_W-1]);
  assign cnt_inc = cnt_b + CNT_W'(1);

`ifdef BOOTH_ACC_SAT_EN
  assign add_res = add_ovf ? (acc_b[ACC_W-1] ? SAT_MIN : SAT_MAX) : sum;
`else
  assign add_res = sum;
`endif

  always_comb begin
    state_d  = state_b;
    acc_d    = acc_b;
    cnt_d    = cnt_b;
    pend_v_d = pend_v_b;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (clr) begin
      state_d  = IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      pend_v_d = 1'b0;
      pend_d   = '0;
    end else if (ev) begin
      case (state_b)
        IDLE: begin
          acc_d   = prod_ext;
          cnt_d   = CNT_W'(1);
          state_d = (N_LAST == CNT_W'(1)) ? HOLD : ACCUM;
        end
        ACCUM: begin
          acc_d = add_res;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf;
          if (cnt_inc == N_LAST) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (pend_v_b) begin
            drop_d = 1'b1;
          end else begin
            pend_v_d = 1'b1;
            pend_d   = p_in;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    acc_valid_d = (state_d == HOLD);
    acc_out_d   = (state_d == HOLD) ? acc_d : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      pend_v_q    <= 1'b0;
      pend_q      <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
      acc_valid_q <= 1'b0;
      acc_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pend_v_q    <= pend_v_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
      acc_valid_q <= acc_valid_d;
      acc_out_q   <= acc_out_d;
    end
  end

  assign acc_out   = acc_out_q;
  assign acc_valid = acc_valid_q;
  assign ovf       = ovf_q;
  assign drop_err  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_prod_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_prod_accum
// Description : Two accumulator instances (24/4 and 16/3) on shared stimulus,
//               checked every cycle against an integer model of the rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_prod_accum;

  localparam int AW_A = 24, NP_A = 4;
  localparam int AW_B = 16, NP_B = 3;
  localparam int P_IDLE = 0, P_ACC = 1, P_HOLD = 2;
`ifdef BOOTH_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] p_in = '0;
  logic        p_rdy = 1'b0;
  logic        clr = 1'b0;
  logic        acc_ready = 1'b0;
  logic [AW_A-1:0] acc_out_a;
  logic [AW_B-1:0] acc_out_b;
  logic        valid_a, valid_b, ovf_a, ovf_b, drop_a, drop_b;

  int nvec = 0;
  int nmis = 0;

  int     m_phase[2];
  longint m_acc[2];
  int     m_cnt[2];
  bit     m_pv[2];
  longint m_pend[2];
  bit     m_ovf[2], m_drop[2], m_last[2];

  always #5 clk = ~clk;

  booth_prod_accum #(.ACC_W(AW_A), .N_PROD(NP_A)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .p_in(p_in), .p_rdy(p_rdy), .clr(clr),
    .acc_out(acc_out_a), .acc_valid(valid_a), .acc_ready(acc_ready),
    .ovf(ovf_a), .drop_err(drop_a)
  );

  booth_prod_accum #(.ACC_W(AW_B), .N_PROD(NP_B)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .p_in(p_in), .p_rdy(p_rdy), .clr(clr),
    .acc_out(acc_out_b), .acc_valid(valid_b), .acc_ready(acc_ready),
    .ovf(ovf_b), .drop_err(drop_b)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset(input int i);
    m_phase[i] = P_IDLE; m_acc[i] = 0; m_cnt[i] = 0; m_pv[i] = 0;
    m_pend[i] = 0; m_ovf[i] = 0; m_drop[i] = 0;
    m_last[i] = 1'b1;  // a level high out of reset must first go low
  endtask

  task automatic m_step(input int i);
    int w, n;
    longint p, lim, s;
    bit ev;
    w = (i == 0) ? AW_A : AW_B;
    n = (i == 0) ? NP_A : NP_B;
    ev = p_rdy && !m_last[i];
    m_last[i] = p_rdy;
    p = longint'($signed(p_in));
    if (clr) begin
      m_phase[i] = P_IDLE; m_acc[i] = 0; m_cnt[i] = 0; m_pv[i] = 0;
      return;
    end
    if (m_phase[i] == P_HOLD && acc_ready) begin
      if (m_pv[i]) begin
        m_acc[i] = m_pend[i]; m_cnt[i] = 1; m_pv[i] = 0;
        m_phase[i] = (n == 1) ? P_HOLD : P_ACC;
      end else begin
        m_phase[i] = P_IDLE; m_acc[i] = 0; m_cnt[i] = 0;
      end
    end
    if (ev) begin
      if (m_phase[i] == P_IDLE) begin
        m_acc[i] = p; m_cnt[i] = 1;
        m_phase[i] = (n == 1) ? P_HOLD : P_ACC;
      end else if (m_phase[i] == P_ACC) begin
        lim = longint'(1) << (w - 1);
        s = m_acc[i] + p;
        if (s >= lim || s < -lim) begin
          m_ovf[i] = 1'b1;
          if (SAT_EN) s = (s >= lim) ? lim - 1 : -lim;
          else        s = (s >= lim) ? s - 2 * lim : s + 2 * lim;
        end
        m_acc[i] = s;
        m_cnt[i]++;
        if (m_cnt[i] == n) m_phase[i] = P_HOLD;
      end else begin
        if (m_pv[i]) m_drop[i] = 1'b1;
        else begin m_pv[i] = 1'b1; m_pend[i] = p; end
      end
    end
  endtask

  // Model advances on each rising edge; outputs are compared 1 time unit later
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) m_reset(i);
      else          m_step(i);
    end
    #1;
    chk("cyc.a.acc_out", longint'($signed(acc_out_a)), (m_phase[0] == P_HOLD) ? m_acc[0] : 0);
    chk("cyc.a.valid",   longint'(valid_a), longint'(m_phase[0] == P_HOLD));
    chk("cyc.a.ovf",     longint'(ovf_a),   longint'(m_ovf[0]));
    chk("cyc.a.drop",    longint'(drop_a),  longint'(m_drop[0]));
    chk("cyc.b.acc_out", longint'($signed(acc_out_b)), (m_phase[1] == P_HOLD) ? m_acc[1] : 0);
    chk("cyc.b.valid",   longint'(valid_b), longint'(m_phase[1] == P_HOLD));
    chk("cyc.b.ovf",     longint'(ovf_b),   longint'(m_ovf[1]));
    chk("cyc.b.drop",    longint'(drop_b),  longint'(m_drop[1]));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int v);
    @(negedge clk);
    p_in = 16'(v);
    p_rdy = 1'b1;
    @(negedge clk);
    p_rdy = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".acc_out_a"}, longint'(acc_out_a), 0);
    chk({nm, ".valid_a"},   longint'(valid_a), 0);
    chk({nm, ".ovf_a"},     longint'(ovf_a), 0);
    chk({nm, ".drop_a"},    longint'(drop_a), 0);
    chk({nm, ".acc_out_b"}, longint'(acc_out_b), 0);
    chk({nm, ".valid_b"},   longint'(valid_b), 0);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_zero(nm);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    cyc(2);
    chk_zero("rst0");
    reset_n = 1'b1;
    cyc(1);

    // Four products into the 4-deep instance
    pulse(100); pulse(200); pulse(-50);
    chk("s1.valid_before", longint'(valid_a), 0);
    pulse(10);
    chk("s1.acc_out", longint'($signed(acc_out_a)), 260);
    chk("s1.valid",   longint'(valid_a), 1);

    // Backpressure, pending slot, drop
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("s2.stable", longint'($signed(acc_out_a)), 260);
    end
    pulse(7);
    chk("s2.no_drop_yet", longint'(drop_a), 0);
    pulse(8);
    chk("s2.drop_err", longint'(drop_a), 1);
    chk("s2.still_260", longint'($signed(acc_out_a)), 260);
    @(negedge clk); acc_ready = 1'b1;
    @(negedge clk); acc_ready = 1'b0;
    chk("s2.seeded_not_valid", longint'(valid_a), 0);
    pulse(1); pulse(2); pulse(3);
    chk("s2.seeded_sum", longint'($signed(acc_out_a)), 13);

    // Overflow on the 16-bit instance
    do_reset("rst_s3");
    cyc(1);
    pulse(16384); pulse(16384); pulse(16384);
    chk("s3.acc_out_b", longint'($signed(acc_out_b)), SAT_EN ? 32767 : -16384);
    chk("s3.ovf_b", longint'(ovf_b), 1);
    chk("s3.valid_b", longint'(valid_b), 1);

    // clr leaves sticky flags alone
    pulse(1); pulse(2);
    chk("s4.drop_b", longint'(drop_b), 1);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("s4.clr_valid_a", longint'(valid_a), 0);
    chk("s4.clr_ovf_b",   longint'(ovf_b), 1);
    chk("s4.clr_drop_b",  longint'(drop_b), 1);
    pulse(5); pulse(5); pulse(5); pulse(5);
    chk("s4.acc_out_a", longint'($signed(acc_out_a)), 20);
    chk("s4.ovf_b_kept", longint'(ovf_b), 1);

    // Reset in ACCUM with p_rdy held high
    do_reset("rst_s5a");
    cyc(1);
    pulse(1); pulse(2);
    @(negedge clk); p_in = 16'd99; p_rdy = 1'b1;
    do_reset("rst_s5b");
    cyc(3);
    chk("s5.no_event_valid", longint'(valid_a), 0);
    chk("s5.no_event_out",   longint'(acc_out_a), 0);
    p_rdy = 1'b0;
    pulse(1); pulse(1); pulse(1); pulse(1);
    chk("s5.acc_out_a", longint'($signed(acc_out_a)), 4);

    // Product coincident with handshake
    @(negedge clk); p_in = 16'd9; p_rdy = 1'b1; acc_ready = 1'b1;
    @(negedge clk); p_rdy = 1'b0; acc_ready = 1'b0;
    chk("s6.valid_a", longint'(valid_a), 0);
    chk("s6.drop_a",  longint'(drop_a), 0);
    pulse(1); pulse(1); pulse(1);
    chk("s6.acc_out_a", longint'($signed(acc_out_a)), 12);
    chk("s6.drop_a_end", longint'(drop_a), 0);

    // Randomised traffic
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      reset_n   = ($urandom_range(0, 200) != 0);
      clr       = ($urandom_range(0, 60) == 0);
      acc_ready = ($urandom_range(0, 3) == 0);
      p_rdy     = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) p_in = 16'($urandom);
      else                           p_in = 16'($urandom_range(0, 400)) - 16'd200;
    end
    @(negedge clk);
    reset_n = 1'b1; clr = 1'b0; acc_ready = 1'b0; p_rdy = 1'b0;
    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
